// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences a shared-ALU datapath with registered strobes and data-SRAM wait states.
// Optional macro ILLEGAL_TRAP_EN: unrecognised opcodes trap into HALT (left only by reset) instead of executing as nop.
module mips_multicycle_ctrl #(
  parameter int MEM_WAIT = 0,
  parameter int JAL_REG  = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       ir_we,
  output logic       mdr_we,
  output logic       aluout_we,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_ctrl,
  output logic       CEN,
  output logic       WEN,
  output logic       OEN,
  output logic       busy,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3, S_WB_R = 4'd4,
    S_MEM_ADR = 4'd5, S_MEM_RD = 4'd6, S_WB_MEM = 4'd7, S_MEM_WR = 4'd8,
    S_BRANCH = 4'd9, S_JUMP = 4'd10, S_JAL = 4'd11, S_JR = 4'd12, S_HALT = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  if (MEM_WAIT < 0 || MEM_WAIT > 15 || JAL_REG < 0 || JAL_REG > 31) begin : g_param_check
    $error("mips_multicycle_ctrl: MEM_WAIT must be 0..15 and JAL_REG 0..31");
  end

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       pc_we_reg;

  // Boundary states fall back to IDLE when run has been dropped.
  function automatic state_t boundary_next(input logic r);
    return r ? S_FETCH : S_IDLE;
  endfunction

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE:   if (run) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_next = (funct == FN_JR) ? S_JR : S_EXEC_R;
          OP_LW, OP_SW:  state_next = S_MEM_ADR;
          OP_BEQ:        state_next = S_BRANCH;
          OP_J:          state_next = S_JUMP;
          OP_JAL:        state_next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:       state_next = S_HALT;
`else
          default:       state_next = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R:  state_next = S_WB_R;
      S_MEM_ADR: begin
        state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        cnt_next   = 4'd0;
      end
      S_MEM_RD: begin
        if (cnt_reg == WAIT_LAST) state_next = S_WB_MEM;
        else                      cnt_next   = cnt_reg + 4'd1;
      end
      S_MEM_WR: begin
        if (cnt_reg == WAIT_LAST) state_next = boundary_next(run);
        else                      cnt_next   = cnt_reg + 4'd1;
      end
      S_WB_R, S_WB_MEM, S_BRANCH, S_JUMP, S_JAL, S_JR: state_next = boundary_next(run);
`ifdef ILLEGAL_TRAP_EN
      S_HALT:  state_next = S_HALT;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_reg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= 4'd0;
      pc_we_reg  <= 1'b0;
      pc_src     <= 2'b00;
      ir_we      <= 1'b0;
      mdr_we     <= 1'b0;
      aluout_we  <= 1'b0;
      reg_we     <= 1'b0;
      reg_dst    <= 2'b00;
      mem_to_reg <= 2'b00;
      alu_src_a  <= 1'b0;
      alu_src_b  <= 2'b00;
      alu_ctrl   <= 4'b0000;
      CEN        <= 1'b1;
      WEN        <= 1'b1;
      OEN        <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      pc_we_reg  <= 1'b0;
      pc_src     <= 2'b00;
      ir_we      <= 1'b0;
      mdr_we     <= 1'b0;
      aluout_we  <= 1'b0;
      reg_we     <= 1'b0;
      reg_dst    <= 2'b00;
      mem_to_reg <= 2'b00;
      alu_src_a  <= 1'b0;
      alu_src_b  <= 2'b00;
      alu_ctrl   <= 4'b0000;
      CEN        <= 1'b1;
      WEN        <= 1'b1;
      OEN        <= 1'b1;
      busy       <= (state_next != S_IDLE);
      case (state_next)
        S_FETCH: begin
          ir_we <= 1'b1; pc_we_reg <= 1'b1; alu_src_b <= 2'b01; alu_ctrl <= ALU_ADD;
        end
        S_DECODE: begin
          aluout_we <= 1'b1; alu_src_b <= 2'b11; alu_ctrl <= ALU_ADD;
        end
        S_EXEC_R: begin
          alu_src_a <= 1'b1; aluout_we <= 1'b1;
          case (funct)
            6'b100010: alu_ctrl <= ALU_SUB;
            6'b100100: alu_ctrl <= ALU_AND;
            6'b100101: alu_ctrl <= ALU_OR;
            6'b101010: alu_ctrl <= ALU_SLT;
            default:   alu_ctrl <= ALU_ADD;
          endcase
        end
        S_WB_R:    begin reg_we <= 1'b1; reg_dst <= 2'b01; end
        S_MEM_ADR: begin
          alu_src_a <= 1'b1; alu_src_b <= 2'b10; alu_ctrl <= ALU_ADD; aluout_we <= 1'b1;
        end
        S_MEM_RD: begin
          CEN <= 1'b0; OEN <= 1'b0; mdr_we <= (cnt_next == WAIT_LAST);
        end
        S_WB_MEM:  begin reg_we <= 1'b1; mem_to_reg <= 2'b01; end
        S_MEM_WR:  begin CEN <= 1'b0; WEN <= 1'b0; end
        S_BRANCH:  begin alu_src_a <= 1'b1; alu_ctrl <= ALU_SUB; pc_src <= 2'b01; end
        S_JUMP:    begin pc_we_reg <= 1'b1; pc_src <= 2'b10; end
        S_JAL: begin
          pc_we_reg <= 1'b1; pc_src <= 2'b10;
          reg_we <= 1'b1; reg_dst <= 2'b10; mem_to_reg <= 2'b10;
        end
        S_JR:      begin pc_we_reg <= 1'b1; pc_src <= 2'b11; end
        default:   ;
      endcase
    end
  end

  // The branch decision is the only strobe that must follow the live ALU flag.
  assign pc_we = pc_we_reg | ((state_reg == S_BRANCH) & zero);
  assign state = state_reg;

endmodule
